// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer around an external 4-bit signed adder.
// Feeds one nibble per cycle LSB first, chains the carry, assembles the wide result and flags.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4,
   parameter int W       = 4*NIBBLES
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         zero_flag,
   output logic         neg_flag,
   output logic         overflow_flag,
   output logic         carry_flag,
   output logic [4:0]   add_a,
   output logic [4:0]   add_b,
   output logic         add_cin,
   input  logic [3:0]   add_s,
   input  logic         add_carry,
   input  logic         add_overflow
);
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES-1);

   typedef enum logic {IDLE, RUN} state_t;

   // Operands as latched at start; b already holds B' (inverted for subtract).
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
   } opnd_t;

   state_t          state, nxt;
   opnd_t           opnd;
   logic [IDXW-1:0] idx;
   logic            carry_q;
   logic [W-1:0]    shadow, shadow_nxt;
   logic            last;

   assign last = (idx == LAST);
   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = RUN;
         RUN:  if (last)  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      shadow_nxt = shadow;
      if (state == RUN) begin
         add_a[3:0] = opnd.a[4*idx +: 4];
         add_b[3:0] = opnd.b[4*idx +: 4];
         add_a[4]   = last & opnd.a[W-1];
         add_b[4]   = last & opnd.b[W-1];
         add_cin    = (idx == '0) ? opnd.sub : carry_q;
         shadow_nxt[4*idx +: 4] = add_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opnd          <= '0;
         idx           <= '0;
         carry_q       <= 1'b0;
         shadow        <= '0;
         done          <= 1'b0;
         result        <= '0;
         zero_flag     <= 1'b0;
         neg_flag      <= 1'b0;
         overflow_flag <= 1'b0;
         carry_flag    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               opnd.a   <= op_a;
               opnd.b   <= op_b ^ {W{sub}};
               opnd.sub <= sub;
               idx      <= '0;
               carry_q  <= 1'b0;
            end
            RUN: begin
               shadow  <= shadow_nxt;
               carry_q <= add_carry;
               idx     <= idx + 1'b1;
               // Result and flags are only published here, so partial sums never show.
               if (last) begin
                  result        <= shadow_nxt;
                  carry_flag    <= add_carry;
                  overflow_flag <= add_overflow;
                  zero_flag     <= (shadow_nxt == '0);
                  neg_flag      <= shadow_nxt[W-1];
                  done          <= 1'b1;
                  idx           <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder attached.
module tb_nibble_serial_add_ctrl;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start, sub;
   logic [W-1:0] op_a, op_b;
   logic         busy, done;
   logic [W-1:0] result;
   logic         zero_flag, neg_flag, overflow_flag, carry_flag;
   logic [4:0]   add_a, add_b;
   logic         add_cin;
   logic [3:0]   add_s;
   logic         add_carry, add_overflow;
   logic [4:0]   sum5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign sum5         = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]} + {4'b0, add_cin};
   assign add_s        = sum5[3:0];
   assign add_carry    = sum5[4];
   assign add_overflow = (add_a[3] == add_b[3]) && (sum5[3] != add_a[3]);

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .sub(sub),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
      .zero_flag(zero_flag), .neg_flag(neg_flag), .overflow_flag(overflow_flag),
      .carry_flag(carry_flag), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_carry(add_carry), .add_overflow(add_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] r,
                          input logic z, input logic n, input logic o, input logic c);
      chk({tag, ".result"}, 32'(result), 32'(r));
      chk({tag, ".zero"}, 32'(zero_flag), 32'(z));
      chk({tag, ".neg"}, 32'(neg_flag), 32'(n));
      chk({tag, ".ovf"}, 32'(overflow_flag), 32'(o));
      chk({tag, ".carry"}, 32'(carry_flag), 32'(c));
   endtask

   // Launch one op; report edges from start edge to done, busy cycles, first-nibble drive.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int lat, output int busyc, output logic fcin,
                        output logic [3:0] fb, output logic stable);
      logic [15:0] prev;
      @(negedge clk);
      op_a = a; op_b = b; sub = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
      prev = result; lat = -1; busyc = 0; stable = 1'b1;
      fcin = add_cin; fb = add_b[3:0];
      for (int j = 0; j < 16; j++) begin
         if (j > 0) @(negedge clk);
         if (done) begin lat = j; break; end
         if (busy) busyc++;
         if (result !== prev) stable = 1'b0;
      end
   endtask

   int         lat, busyc, ndone;
   logic       fcin, stable;
   logic [3:0] fb;

   initial begin
      reset_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.add_a", 32'(add_a), 0);
      chk("rst.add_b", 32'(add_b), 0);
      chk("rst.add_cin", 32'(add_cin), 0);
      chk_out("rst", 16'h0000, 0, 0, 0, 0);
      reset_n = 1'b1;
      @(negedge clk);

      do_op(16'h7FFF, 16'h0001, 1'b0, lat, busyc, fcin, fb, stable);
      chk("t1.latency", 32'(lat), 4);
      chk("t1.busy_cycles", 32'(busyc), 4);
      chk("t1.no_partial", 32'(stable), 1);
      chk_out("t1", 16'h8000, 0, 1, 1, 0);
      @(negedge clk);
      chk("t1.done_pulse", 32'(done), 0);
      chk("t1.idle_add_a", 32'(add_a), 0);

      do_op(16'hFFFF, 16'h0001, 1'b0, lat, busyc, fcin, fb, stable);
      chk("t2.latency", 32'(lat), 4);
      chk_out("t2", 16'h0000, 1, 0, 0, 1);

      do_op(16'h0003, 16'h0008, 1'b1, lat, busyc, fcin, fb, stable);
      chk("t3.latency", 32'(lat), 4);
      chk("t3.first_cin", 32'(fcin), 1);
      chk("t3.first_b", 32'(fb), 32'h7);
      chk("t3.no_partial", 32'(stable), 1);
      chk_out("t3", 16'hFFFB, 0, 1, 0, 0);

      do_op(16'h8000, 16'h0001, 1'b1, lat, busyc, fcin, fb, stable);
      chk("t4.latency", 32'(lat), 4);
      chk_out("t4", 16'h7FFF, 0, 0, 1, 1);

      // Second start while busy must be ignored.
      @(negedge clk);
      op_a = 16'h0005; op_b = 16'h0003; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      op_a = 16'h0001; op_b = 16'h0001;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int j = 0; j < 10; j++) begin
         if (done) begin
            ndone++;
            chk("t5.first_result", 32'(result), 32'h0008);
         end
         @(negedge clk);
      end
      chk("t5.done_count", 32'(ndone), 1);

      // Start issued in the done cycle is accepted.
      do_op(16'h0004, 16'h0004, 1'b0, lat, busyc, fcin, fb, stable);
      chk("t5.mid_result", 32'(result), 32'h0008);
      op_a = 16'h0001; op_b = 16'h0001; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int j = 0; j < 16; j++) begin
         if (j > 0) @(negedge clk);
         if (done) begin lat = j; break; end
      end
      chk("t5.chain_latency", 32'(lat), 4);
      chk("t5.chain_result", 32'(result), 32'h0002);

      // Abort mid-run with reset.
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h1111; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("t6.busy", 32'(busy), 0);
      chk("t6.done", 32'(done), 0);
      chk_out("t6", 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("t6.no_done", 32'(ndone), 0);
      do_op(16'h1234, 16'h1111, 1'b0, lat, busyc, fcin, fb, stable);
      chk("t6.after_latency", 32'(lat), 4);
      chk_out("t6.after", 16'h2345, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
